// File: rtl/sn74ls31_tapline.sv
// sn74ls31_tapline: clocked tapped delay line with glitch filter, modelled on the LS31 delay element
// Ports: clk system clock; clr_n async active-low clear; a async input; en stage enable;
//        tap delay tap select; y filtered delayed output (inverted when INVERT=1);
//        yd raw tapped value; rise/fall one-cycle pulses on y going 0->1 / 1->0
module sn74ls31_tapline #(
    parameter int DEPTH  = 8,
    parameter int MINW   = 2,
    parameter int INVERT = 1
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       a,
    input  logic       en,
    input  logic [3:0] tap,
    output logic       y,
    output logic       yd,
    output logic       rise,
    output logic       fall
);
    typedef enum logic [1:0] {LO, LO_CHK, HI, HI_CHK} state_t;
    localparam logic [3:0] LAST = 4'(DEPTH - 1);
    localparam logic [3:0] LIM  = 4'(MINW - 1);
    localparam logic       INV  = 1'(INVERT);
    state_t           state_q, state_d;
    logic             s1_q, s2_q;
    logic [DEPTH-1:0] sr_q, sr_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             filt_q, filt_d;
    logic             rise_q, rise_d, fall_q, fall_d;
    logic [3:0]       tap_eff;
    logic [15:0]      sr_ext;
    logic             tapped;
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            sr_q    <= '0;
            state_q <= LO;
            cnt_q   <= '0;
            filt_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            s1_q    <= a;
            s2_q    <= s1_q;
            sr_q    <= sr_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            filt_q  <= filt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end
    // Out-of-range taps clamp to the last stage; the padded copy keeps the index width uniform.
    always_comb begin
        tap_eff = (tap > LAST) ? LAST : tap;
        sr_ext  = 16'(sr_q);
        tapped  = sr_ext[tap_eff];
        sr_d    = en ? {sr_q[DEPTH-2:0], s2_q} : sr_q;
    end
    // A level change must persist MINW enabled cycles at the tap before filt follows it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        filt_d  = filt_q;
        if (en) begin
            case (state_q)
                LO: if (tapped) begin
                    if (MINW == 1) begin
                        state_d = HI;
                        filt_d  = 1'b1;
                    end else begin
                        state_d = LO_CHK;
                        cnt_d   = 4'd1;
                    end
                end
                LO_CHK: if (!tapped) begin
                    state_d = LO;
                    cnt_d   = '0;
                end else if (cnt_q == LIM) begin
                    state_d = HI;
                    cnt_d   = '0;
                    filt_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
                HI: if (!tapped) begin
                    if (MINW == 1) begin
                        state_d = LO;
                        filt_d  = 1'b0;
                    end else begin
                        state_d = HI_CHK;
                        cnt_d   = 4'd1;
                    end
                end
                default: if (tapped) begin
                    state_d = HI;
                    cnt_d   = '0;
                end else if (cnt_q == LIM) begin
                    state_d = LO;
                    cnt_d   = '0;
                    filt_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            endcase
        end
    end
    // Edge pulses follow the output pin's polarity, so they line up with the change on y.
    always_comb begin
        rise_d = (filt_d != filt_q) & (filt_d ^ INV);
        fall_d = (filt_d != filt_q) & ~(filt_d ^ INV);
        y      = filt_q ^ INV;
        yd     = tapped;
        rise   = rise_q;
        fall   = fall_q;
    end
endmodule
